arb_rr_4_1: RTL and testbench
=============================

# arb_rr_4_1

Four-channel round-robin arbiter with a registered output stage. It is the sequential front end of the 4:1 data multiplexer. It picks one of four valid/ready input channels per cycle, fair round-robin. The winner's data and its 2-bit channel index are latched into an output register, which presents them downstream as a single valid/ready stream. Downstream logic uses out_sel wherever the selected channel must be known.

## Interface
- W, default 4: data width of every channel and of out_data.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  4  per-channel request; bit i belongs to channel i.
- d0, d1, d2, d3  input  W each  channel data.
- in_ready  output  4  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a transfer.
- out_data  output  W  data of the held transfer.
- out_sel  output  2  index (0..3) of the channel that produced out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

## Operation
- State: output register (out_valid, out_data, out_sel), plus a 2-bit pointer last_grant.
- can_accept = !out_valid | out_ready.
- Grant (combinational): search in_valid starting at channel (last_grant+1) mod 4, wrapping upward. The first valid channel wins, giving grant index g.
  - Example: if last_grant=1, the search order is 2,3,0,1.
- in_ready = onehot(g) when any in_valid is high and can_accept is high; otherwise 4'b0000.
- Input handshake on channel i: in_valid[i] & in_ready[i]. On that edge:
  - out_data <= d_g
  - out_sel <= g
  - out_valid <= 1
  - last_grant <= g
- Output handshake: out_valid & out_ready.
  - If it completes with no input handshake in the same cycle, out_valid <= 0. out_data and out_sel hold their last values.
- Without an output handshake, out_valid, out_data and out_sel are stable while out_valid=1.
- last_grant changes only on an input handshake. Requests that are not granted do not move the pointer.
- Upstream rule: once in_valid[i] rises, it stays high with stable d_i until accepted. The block does not check this.
- Data is passed through unchanged, including X bits. No data-dependent behaviour.
- Single requester: it is granted every cycle that can_accept is high. The pointer then equals that channel.

## Timing
- Reset values, after the first rising edge with rst=1:
  - out_valid=0, out_data=0, out_sel=0.
  - last_grant=3, so channel 0 has first priority.
  - in_ready is 0 while rst=1.
- Latency: input handshake at edge N makes out_valid=1 with the matching out_data/out_sel visible after edge N.
- Throughput: one transfer per cycle while out_ready stays high.
  - Simultaneous drain and fill in one cycle: the register is replaced, out_valid stays 1, and no bubble is inserted.
- Backpressure: out_valid=1 with out_ready=0 forces in_ready=0. No input is lost or duplicated.
- Combinational paths:
  - in_valid -> in_ready.
  - out_ready -> in_ready.
  - There is no path from any input to out_valid, out_data or out_sel.
- Reset mid-operation: a held transfer is discarded, out_valid=0 after the edge, and the pointer returns to 3. Reset overrides a same-cycle handshake.
- Fairness: with all four channels continuously valid and out_ready=1, grants follow the order 0,1,2,3,0,... Each channel waits at most 3 grants.

## Test plan
- Reset, then all in_valid=0 for 3 cycles. Required: out_valid=0, in_ready=0000, out_data=0, out_sel=0.
- All four channels valid with d0..d3 = a,b,c,d, and out_ready=1 constantly. Required:
  - in_ready cycles 0001, 0010, 0100, 1000.
  - out_data a,b,c,d,a with out_sel 0,1,2,3,0, one cycle after each grant, no bubbles.
- Only channel 2 valid with d2=7, out_ready=1 for 4 cycles. Required: in_ready=0100 every cycle, out_data=7 and out_sel=2 each cycle.
- Backpressure: transfer from channel 1 (d1=5) held while out_ready=0 for 3 cycles, with channels 0 and 3 valid. Required:
  - out_valid=1, out_data=5, out_sel=1 stable, in_ready=0000.
  - After out_ready=1: next grant is channel 3, then channel 0.
- Skip fairness: last_grant=0, in_valid=1001. Required: grant channel 3 (in_ready=1000), then channel 0.
- Reset mid-stream with out_valid=1 and out_ready=0, rst=1 for one cycle. Required:
  - out_valid=0 after the edge.
  - With all channels valid afterwards, the first grant is channel 0.

Source files
------------

// File: rtl/arb_rr_4_1.sv
// arb_rr_4_1: four-channel round-robin arbiter with a registered valid/ready output stage
module arb_rr_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);
    logic [1:0]   last_grant;
    logic [1:0]   g;
    logic [W-1:0] d_g;
    logic         fire;
    always_comb begin
        g = last_grant;
        for (int k = 3; k >= 0; k--)
            if (in_valid[last_grant + 2'(k + 1)]) g = last_grant + 2'(k + 1);
    end
    assign fire     = !rst && (|in_valid) && (!out_valid || out_ready);
    assign in_ready = fire ? 4'(1) << g : 4'b0000;
    assign d_g      = g[1] ? (g[0] ? d3 : d2) : (g[0] ? d1 : d0);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 2'd0;
            last_grant <= 2'd3;
        end else if (fire) begin
            out_valid  <= 1'b1;
            out_data   <= d_g;
            out_sel    <= g;
            last_grant <= g;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_rr_4_1.sv
// tb_arb_rr_4_1: directed and randomized checks of arb_rr_4_1 against a behavioural model
module tb_arb_rr_4_1;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] dd [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;
    int           tests = 0;
    int           fails = 0;
    bit           mv;
    logic [W-1:0] md;
    int           ms, ptr, acc_g;
    always #5 clk = ~clk;
    arb_rr_4_1 #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .d0(dd[0]), .d1(dd[1]), .d2(dd[2]), .d3(dd[3]),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic int pick();
        for (int off = 1; off <= 4; off++)
            if (in_valid[(ptr + off) % 4]) return (ptr + off) % 4;
        return -1;
    endfunction
    task automatic step(input logic ordy);
        int g;
        logic [3:0] exp_rdy;
        out_ready = ordy;
        #1;
        g = pick();
        exp_rdy = (!rst && g >= 0 && (!mv || ordy)) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        acc_g = -1;
        if (rst) begin
            mv = 0; md = '0; ms = 0; ptr = 3;
        end else if (exp_rdy != 0) begin
            mv = 1; md = dd[g]; ms = g; ptr = g; acc_g = g;
        end else if (mv && ordy) begin
            mv = 0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(mv));
        check("out_data", 32'(out_data), 32'(md));
        check("out_sel", 32'(out_sel), 32'(ms));
        @(negedge clk);
    endtask
    initial begin
        mv = 0; md = '0; ms = 0; ptr = 3; acc_g = -1;
        rst = 1; in_valid = 4'b0; out_ready = 0;
        for (int i = 0; i < 4; i++) dd[i] = '0;
        @(negedge clk);
        step(0);
        rst = 0;
        for (int i = 0; i < 3; i++) step(1);
        check("idle_data", 32'(out_data), 32'd0);
        dd[0] = 4'ha; dd[1] = 4'hb; dd[2] = 4'hc; dd[3] = 4'hd;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("rr_order", 32'(out_sel), 32'(i % 4));
        end
        in_valid = 4'b0100; dd[2] = 4'd7;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("single_data", 32'(out_data), 32'd7);
        end
        in_valid = 4'b0000;
        step(1);
        in_valid = 4'b0010; dd[1] = 4'd5; dd[0] = 4'd1; dd[3] = 4'd9;
        step(0);
        in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("bp_data", 32'(out_data), 32'd5);
        end
        step(1);
        check("bp_next3", 32'(out_sel), 32'd3);
        in_valid = 4'b0001;
        step(1);
        check("bp_then0", 32'(out_sel), 32'd0);
        in_valid = 4'b1001;
        step(1);
        check("skip3", 32'(out_sel), 32'd3);
        step(1);
        check("skip0", 32'(out_sel), 32'd0);
        in_valid = 4'b0000;
        step(0);
        rst = 1;
        step(0);
        check("rst_mid", 32'(out_valid), 32'd0);
        rst = 0; in_valid = 4'b1111;
        step(1);
        check("rst_first", 32'(out_sel), 32'd0);
        for (int n = 0; n < 400; n++) begin
            if (acc_g >= 0) in_valid[acc_g] = 1'b0;
            for (int i = 0; i < 4; i++)
                if (!in_valid[i] && $urandom_range(1) == 1) begin
                    in_valid[i] = 1'b1;
                    dd[i] = W'($urandom_range(15));
                end
            rst = ($urandom_range(49) == 0);
            step(1'($urandom_range(1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
